irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: window base, register offsets, FSM states.
package irq_ctrl_pkg;

  localparam logic [31:0] IRQ_BEGIN = 32'h0000_7F20;

  localparam logic [31:0] OFF_PEND = 32'd0;
  localparam logic [31:0] OFF_MASK = 32'd4;
  localparam logic [31:0] OFF_ID   = 32'd8;
  localparam logic [31:0] OFF_EOI  = 32'd12;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SVC  = 2'b10
  } irqState_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered set bit (bit 0 is highest priority).
module irq_prio_enc #(
  parameter int NSRC = 6
) (
  input  logic [NSRC-1:0] reqVec,
  output logic [2:0]      index,
  output logic            valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    index = '0;
    valid = |reqVec;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (reqVec[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller (PEND/MASK/ID/EOI) feeding CP0 HWInt and IrqReq.
// Define IRQ_CTRL_EDGE_DETECT_EN for rising-edge sources; default build is level-sensitive.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IRQ_BEGIN,
  parameter int          NSRC      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     AddrIn,
  input  logic [31:0]     DataIn,
  input  logic [3:0]      ByteEn,
  output logic [31:0]     RdataOut,
  input  logic [NSRC-1:0] IrqSrc,
  input  logic            IntAck,
  output logic [NSRC-1:0] HWInt,
  output logic            IrqReq
);

  irqState_t       state;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pendMasked;
  logic [NSRC-1:0] pendClr;
  logic [NSRC-1:0] srcActive;
  logic            idValid;
  logic [2:0]      idIndex;
  logic [2:0]      encIndex;
  logic            encValid;
  logic            wrEn;
  logic            selPend, selMask, selId, selEoi;
  logic            unusedDataHi;

  assign wrEn    = (ByteEn == 4'b1111);
  assign selPend = (AddrIn == BASE_ADDR + OFF_PEND);
  assign selMask = (AddrIn == BASE_ADDR + OFF_MASK);
  assign selId   = (AddrIn == BASE_ADDR + OFF_ID);
  assign selEoi  = (AddrIn == BASE_ADDR + OFF_EOI);

  assign unusedDataHi = ^DataIn[31:NSRC];

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [NSRC-1:0] prevSrc;
  logic            histValid;

  // histValid masks the first edge after reset so sources already high do not look like new edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevSrc   <= '0;
      histValid <= 1'b0;
    end else begin
      prevSrc   <= IrqSrc;
      histValid <= 1'b1;
    end
  end

  assign srcActive = IrqSrc & ~prevSrc & {NSRC{histValid}};
`else
  assign srcActive = IrqSrc;
`endif

  assign pendClr    = (wrEn && selPend) ? DataIn[NSRC-1:0] : '0;
  assign pendMasked = pend & mask;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
    end else begin
      if (wrEn && selMask) mask <= DataIn[NSRC-1:0];
      // Set is OR-ed after the clear so a simultaneous new event survives W1C.
      pend <= (pend & ~pendClr) | srcActive;
    end
  end

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .reqVec (pendMasked),
    .index  (encIndex),
    .valid  (encValid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idValid <= 1'b0;
      idIndex <= '0;
    end else begin
      case (state)
        IDLE: if (|pendMasked) state <= REQ;
        REQ: begin
          if (IntAck) begin
            state   <= SVC;
            idValid <= encValid;
            idIndex <= encIndex;
          end else if (!(|pendMasked)) begin
            state <= IDLE;
          end
        end
        SVC: begin
          if (wrEn && selEoi) begin
            state   <= IDLE;
            idValid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IrqReq = (state == REQ);
  assign HWInt  = (state == REQ) ? pendMasked : '0;

  always_comb begin
    RdataOut = '0;
    if (selPend)      RdataOut = 32'(pend);
    else if (selMask) RdataOut = 32'(mask);
    else if (selId)   RdataOut = {idValid, 28'd0, idIndex};
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl in its default (level-sensitive) build.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam logic [31:0] A_PEND  = IRQ_BEGIN + OFF_PEND;
  localparam logic [31:0] A_MASK  = IRQ_BEGIN + OFF_MASK;
  localparam logic [31:0] A_ID    = IRQ_BEGIN + OFF_ID;
  localparam logic [31:0] A_EOI   = IRQ_BEGIN + OFF_EOI;
  localparam logic [31:0] A_UNMAP = IRQ_BEGIN + 32'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] AddrIn;
  logic [31:0] DataIn;
  logic [3:0]  ByteEn;
  logic [31:0] RdataOut;
  logic [5:0]  IrqSrc;
  logic        IntAck;
  logic [5:0]  HWInt;
  logic        IrqReq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  irq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .AddrIn   (AddrIn),
    .DataIn   (DataIn),
    .ByteEn   (ByteEn),
    .RdataOut (RdataOut),
    .IrqSrc   (IrqSrc),
    .IntAck   (IntAck),
    .HWInt    (HWInt),
    .IrqReq   (IrqReq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    AddrIn = a;
    DataIn = d;
    ByteEn = be;
    tick();
    ByteEn = 4'b0000;
    AddrIn = 32'h0;
    DataIn = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    AddrIn = a;
    #1;
    d = RdataOut;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL reset_irqreq: got %b expected 0", IrqReq); end
    checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL reset_hwint: got %h expected 00", HWInt); end
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h expected 00000000", rd); end
    busRead(A_MASK, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected 00000000", rd); end
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_id: got %h expected 00000000", rd); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mask_rw();
    busWrite(A_MASK, 32'hFFFF_FFFF, 4'b1111);
    busRead(A_MASK, rd);
    checks++; if (rd !== 32'h0000_003F) begin errors++; $display("FAIL mask_upper_bits: got %h expected 0000003f", rd); end
    busWrite(A_MASK, 32'h0, 4'b0111);
    busRead(A_MASK, rd);
    checks++; if (rd !== 32'h0000_003F) begin errors++; $display("FAIL mask_partial_be: got %h expected 0000003f", rd); end
    busWrite(A_UNMAP, 32'h0, 4'b1111);
    busRead(A_MASK, rd);
    checks++; if (rd !== 32'h0000_003F) begin errors++; $display("FAIL mask_unmapped_wr: got %h expected 0000003f", rd); end
    busRead(A_UNMAP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL read_unmapped: got %h expected 00000000", rd); end
    busRead(A_EOI, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL read_eoi: got %h expected 00000000", rd); end
    busWrite(A_MASK, 32'h0, 4'b1111);
  endtask

  task automatic test_basic();
    busWrite(A_MASK, 32'h03, 4'b1111);
    IrqSrc = 6'h02;
    tick();
    IrqSrc = 6'h00;
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL basic_pend: got %h expected 00000002", rd); end
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL basic_irq_early: got %b expected 0", IrqReq); end
    tick();
    checks++; if (IrqReq !== 1'b1) begin errors++; $display("FAIL basic_irqreq: got %b expected 1", IrqReq); end
    checks++; if (HWInt !== 6'h02) begin errors++; $display("FAIL basic_hwint: got %h expected 02", HWInt); end
    busWrite(A_PEND, 32'h02, 4'b1111);
    tick();
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got %b expected 0", IrqReq); end
  endtask

  task automatic test_ack_id();
    busWrite(A_MASK, 32'h3F, 4'b1111);
    IrqSrc = 6'h06;
    tick();
    tick();
    checks++; if (IrqReq !== 1'b1) begin errors++; $display("FAIL ack_irqreq: got %b expected 1", IrqReq); end
    checks++; if (HWInt !== 6'h06) begin errors++; $display("FAIL ack_hwint: got %h expected 06", HWInt); end
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL svc_irqreq: got %b expected 0", IrqReq); end
    checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL svc_hwint: got %h expected 00", HWInt); end
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h8000_0001) begin errors++; $display("FAIL svc_id: got %h expected 80000001", rd); end
  endtask

  task automatic test_svc_hold();
    IrqSrc = 6'h00;
    busWrite(A_PEND, 32'h3F, 4'b1111);
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hold_pend_clr: got %h expected 00000000", rd); end
    IrqSrc = 6'h01;
    tick();
    IrqSrc = 6'h00;
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL hold_pend_set: got %h expected 00000001", rd); end
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL hold_no_nest: got %b expected 0", IrqReq); end
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h8000_0001) begin errors++; $display("FAIL hold_id_kept: got %h expected 80000001", rd); end
    busWrite(A_EOI, 32'hDEAD_BEEF, 4'b1111);
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL eoi_idle: got %b expected 0", IrqReq); end
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL eoi_id_valid: got %h expected 00000001", rd); end
    tick();
    checks++; if (IrqReq !== 1'b1) begin errors++; $display("FAIL eoi_rereq: got %b expected 1", IrqReq); end
    checks++; if (HWInt !== 6'h01) begin errors++; $display("FAIL eoi_hwint: got %h expected 01", HWInt); end
  endtask

  task automatic test_w1c_collision();
    AddrIn = A_PEND;
    DataIn = 32'h1;
    ByteEn = 4'b1111;
    IrqSrc = 6'h01;
    tick();
    ByteEn = 4'b0000;
    IrqSrc = 6'h00;
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL w1c_set_wins: got %h expected 00000001", rd); end
    busWrite(A_PEND, 32'h1, 4'b1111);
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h expected 00000000", rd); end
    tick();
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL w1c_idle: got %b expected 0", IrqReq); end
  endtask

  task automatic test_mask_to_idle();
    IrqSrc = 6'h04;
    tick();
    IrqSrc = 6'h00;
    tick();
    checks++; if (IrqReq !== 1'b1) begin errors++; $display("FAIL m2i_req: got %b expected 1", IrqReq); end
    checks++; if (HWInt !== 6'h04) begin errors++; $display("FAIL m2i_hwint: got %h expected 04", HWInt); end
    busWrite(A_MASK, 32'h0, 4'b1111);
    tick();
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL m2i_idle: got %b expected 0", IrqReq); end
    checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL m2i_hwint0: got %h expected 00", HWInt); end
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("FAIL m2i_pend: got %h expected 00000004", rd); end
  endtask

  task automatic test_reset_mid_svc();
    busWrite(A_MASK, 32'h3F, 4'b1111);
    tick();
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h8000_0002) begin errors++; $display("FAIL rst_pre_id: got %h expected 80000002", rd); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (IrqReq !== 1'b0) begin errors++; $display("FAIL rst_irqreq: got %b expected 0", IrqReq); end
    checks++; if (HWInt !== 6'h00) begin errors++; $display("FAIL rst_hwint: got %h expected 00", HWInt); end
    busRead(A_MASK, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h expected 00000000", rd); end
    busRead(A_PEND, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_pend: got %h expected 00000000", rd); end
    busRead(A_ID, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_id: got %h expected 00000000", rd); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    AddrIn = 32'h0;
    DataIn = 32'h0;
    ByteEn = 4'b0000;
    IrqSrc = 6'h00;
    IntAck = 1'b0;
    test_reset();
    test_mask_rw();
    test_basic();
    test_ack_id();
    test_svc_hold();
    test_w1c_collision();
    test_mask_to_idle();
    test_reset_mid_svc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
